// File: rtl/fifo_pkt_gen.sv
// -----------------------------------------------------------------------------
// fifo_pkt_gen
// Test-packet source. On a start request it writes one framed packet into a
// downstream FIFO write port: two header words, then payload words generated
// from a selectable pattern. It honours FIFO-full backpressure, can be aborted,
// and counts completed packets.
//
// Handshake: fs is a level request sampled in IDLE. The packet is written in
// WORK, one word per cycle in which fifo_txen=1 (fifo_txen = !fifo_full while
// in WORK, so a full FIFO never receives a write and no word is lost). fd (or
// abort) stays high until fs is dropped; the block then returns to IDLE. A new
// packet needs fs to go low and high again.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fs              start request (level)
//   data_len        words per packet including both header words
//   mode            payload pattern: 0 index, 1 seed, 2 seed+index, 3 LFSR
//   seed            pattern seed
//   err             abort request (honoured in HEAD and WORK)
//   fifo_full       downstream FIFO full
//   fifo_txd        write data (0 outside WORK)
//   fifo_txen       write enable
//   fd              packet done
//   abort           packet aborted
//   pkt_cnt         completed packets, wraps at 16 bits
//   state_o         current state (debug)
//   byte_cnt_o      words written in the current packet (debug)
//
// Optional feature: define FIFO_PKT_GEN_CHECKSUM_EN to append a trailer word
// holding the XOR of all len words of the packet.
// -----------------------------------------------------------------------------
module fifo_pkt_gen #(
  parameter int         DATA_W    = 8,
  parameter int         LEN_W     = 12,
  parameter logic [7:0] HEAD0     = 8'h55,
  parameter logic [7:0] HEAD1     = 8'hAA,
  parameter logic [7:0] LFSR_TAPS = 8'hB8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  input  logic [LEN_W-1:0]  data_len,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              err,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] fifo_txd,
  output logic              fifo_txen,
  output logic              fd,
  output logic              abort,
  output logic [15:0]       pkt_cnt,
  output logic [2:0]        state_o,
  output logic [LEN_W-1:0]  byte_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HEAD  = 3'd1;
  localparam logic [2:0] S_WORK  = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam logic [DATA_W-1:0] HEAD0_W = DATA_W'(HEAD0);
  localparam logic [DATA_W-1:0] HEAD1_W = DATA_W'(HEAD1);
  localparam logic [DATA_W-1:0] TAPS_W  = DATA_W'(LFSR_TAPS);

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [1:0]        pmode_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] pat_q;
  logic [15:0]       pkt_cnt_q;

  logic              wr;         // a word is written this cycle
  logic              last_word;  // current index is the final data word
  logic              final_wr;   // this write completes the packet
  logic [DATA_W-1:0] payload;
  logic [DATA_W-1:0] word;

`ifdef FIFO_PKT_GEN_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;     // XOR of data words written so far
  logic              trl_q;      // trailer word is the next write
`endif

  assign last_word = (idx_q == len_q - LEN_W'(1));

`ifdef FIFO_PKT_GEN_CHECKSUM_EN
  assign final_wr = trl_q;
`else
  assign final_wr = last_word;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fs) state_d = S_HEAD;
      S_HEAD: begin
        if (err) state_d = S_ABORT;
`ifdef FIFO_PKT_GEN_CHECKSUM_EN
        else     state_d = S_WORK;   // len==0 still writes the trailer
`else
        else if (len_q == '0) state_d = S_LAST;
        else                  state_d = S_WORK;
`endif
      end
      S_WORK: begin
        if (err)                 state_d = S_ABORT;
        else if (wr && final_wr) state_d = S_LAST;
      end
      S_LAST:  if (!fs) state_d = S_IDLE;
      S_ABORT: if (!fs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    payload = '0;
    case (pmode_q)
      2'd0: payload = DATA_W'(idx_q);
      2'd1: payload = seed_q;
      2'd2: payload = seed_q + DATA_W'(idx_q);
      default: payload = pat_q;
    endcase

    if (idx_q == '0)               word = HEAD0_W;
    else if (idx_q == LEN_W'(1))   word = HEAD1_W;
    else                           word = payload;
`ifdef FIFO_PKT_GEN_CHECKSUM_EN
    if (trl_q) word = csum_q;
`endif

    wr        = (state_q == S_WORK) && !fifo_full;
    fifo_txen = wr;
    fifo_txd  = (state_q == S_WORK) ? word : '0;
    fd        = (state_q == S_LAST);
    abort     = (state_q == S_ABORT);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      idx_q     <= '0;
      pmode_q   <= '0;
      seed_q    <= '0;
      pat_q     <= '0;
      pkt_cnt_q <= '0;
`ifdef FIFO_PKT_GEN_CHECKSUM_EN
      csum_q    <= '0;
      trl_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (fs) begin
          len_q   <= data_len;
          pmode_q <= mode;
          seed_q  <= seed;
          // An all-zero LFSR would lock up, so seed 0 starts at 1 instead.
          pat_q   <= (mode == 2'd3 && seed == '0) ? DATA_W'(1) : seed;
        end
        S_HEAD: begin
          idx_q <= '0;
`ifdef FIFO_PKT_GEN_CHECKSUM_EN
          csum_q <= '0;
          trl_q  <= (len_q == '0);
`endif
        end
        S_WORK: if (wr) begin
`ifdef FIFO_PKT_GEN_CHECKSUM_EN
          if (!trl_q) begin
            csum_q <= csum_q ^ word;
            idx_q  <= idx_q + LEN_W'(1);
            if (last_word) trl_q <= 1'b1;
            if (pmode_q == 2'd3 && idx_q >= LEN_W'(2))
              pat_q <= {pat_q[DATA_W-2:0], ^(pat_q & TAPS_W)};
          end
`else
          idx_q <= idx_q + LEN_W'(1);
          if (pmode_q == 2'd3 && idx_q >= LEN_W'(2))
            pat_q <= {pat_q[DATA_W-2:0], ^(pat_q & TAPS_W)};
`endif
        end
        default: ;
      endcase

      // The debug byte count reads 0 whenever the block is idle.
      if (state_d == S_IDLE) idx_q <= '0;

      if (state_d == S_LAST && state_q != S_LAST)
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt    = pkt_cnt_q;
  assign state_o    = state_q;
  assign byte_cnt_o = idx_q;

endmodule

// File: tb/tb_fifo_pkt_gen.sv
`timescale 1ns/1ps
module tb_fifo_pkt_gen;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs = 1'b0;
  logic [11:0] data_len = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  seed = '0;
  logic        err = 1'b0;
  logic        fifo_full = 1'b0;
  logic [7:0]  fifo_txd;
  logic        fifo_txen;
  logic        fd;
  logic        abort;
  logic [15:0] pkt_cnt;
  logic [2:0]  state_o;
  logic [11:0] byte_cnt_o;

  always #5 clk = ~clk;

  fifo_pkt_gen dut (
    .clk        (clk),
    .rst        (rst),
    .fs         (fs),
    .data_len   (data_len),
    .mode       (mode),
    .seed       (seed),
    .err        (err),
    .fifo_full  (fifo_full),
    .fifo_txd   (fifo_txd),
    .fifo_txen  (fifo_txen),
    .fd         (fd),
    .abort      (abort),
    .pkt_cnt    (pkt_cnt),
    .state_o    (state_o),
    .byte_cnt_o (byte_cnt_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] exp_pkt = '0;
  int          tests_run = 0;
  int          fails = 0;
  int          bad_wr = 0;

  // Capture every word the DUT writes; flag any write into a full FIFO.
  always @(negedge clk) begin
    if (fifo_txen === 1'b1) got_q.push_back(fifo_txd);
    if (fifo_txen === 1'b1 && fifo_full === 1'b1) bad_wr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: the word list a packet must produce.
  function automatic void build_exp(input int len, input int md, input logic [7:0] sd);
    logic [7:0] r, w, x;
    exp_q.delete();
    r = (md == 3 && sd == 8'h00) ? 8'h01 : sd;
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (i == 0)      w = 8'h55;
      else if (i == 1) w = 8'hAA;
      else begin
        case (md)
          0: w = 8'(i);
          1: w = sd;
          2: w = 8'(int'(sd) + i);
          default: begin
            w = r;
            r = {r[6:0], ^(r & 8'hB8)};
          end
        endcase
      end
      exp_q.push_back(w);
      x = x ^ w;
    end
`ifdef FIFO_PKT_GEN_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one packet, random backpressure, optional abort after err_at writes
  // ---------------------------------------------------------------------------
  task automatic run_pkt(input string tag, input int len, input int md, input int sd,
                         input int full_pct, input int err_at);
    int cyc;
    bit done;
    bit err_sent;
    int nwr;
    build_exp(len, md, 8'(sd));
    got_q.delete();
    @(posedge clk); #1;
    fs = 1'b1; data_len = 12'(len); mode = 2'(md); seed = 8'(sd);
    fifo_full = 1'b0; err = 1'b0;
    cyc = 0; done = 1'b0; err_sent = 1'b0;
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      // Inputs change freely once the packet has started.
      data_len = 12'($urandom); mode = 2'($urandom); seed = 8'($urandom);
      err = 1'b0;
      if (err_at >= 0 && !err_sent && got_q.size() == err_at) begin
        err = 1'b1; err_sent = 1'b1; fifo_full = 1'b0;
      end else begin
        fifo_full = ($urandom_range(0, 99) < full_pct);
      end
      @(negedge clk);
      cyc++;
      if (fd === 1'b1 || abort === 1'b1) done = 1'b1;
    end
    @(posedge clk); #1;
    err = 1'b0; fifo_full = 1'b0;
    check({tag, "_finished"}, 32'(done), 32'd1);

    if (err_at < 0) begin
      exp_pkt = exp_pkt + 16'd1;
      check({tag, "_fd"}, 32'(fd), 32'd1);
      check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
      check({tag, "_byte_cnt"}, 32'(byte_cnt_o), 32'(len));
    end else begin
      while (exp_q.size() > err_at + 1) void'(exp_q.pop_back());
      check({tag, "_abort"}, 32'(abort), 32'd1);
      check({tag, "_abort_fd"}, 32'(fd), 32'd0);
      check({tag, "_abort_pkt"}, 32'(pkt_cnt), 32'(exp_pkt));
    end

    // fs held high: block must sit in its end state without writing.
    repeat (3) @(negedge clk);
    check({tag, "_hold_state"}, 32'(state_o), (err_at < 0) ? 32'd3 : 32'd4);
    nwr = got_q.size();
    check({tag, "_nwords"}, 32'(nwr), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < nwr) check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));

    @(posedge clk); #1;
    fs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_state"}, 32'(state_o), 32'd0);
    check({tag, "_idle_fd_abort"}, {30'd0, fd, abort}, 32'd0);
    check({tag, "_idle_byte_cnt"}, 32'(byte_cnt_o), 32'd0);
    check({tag, "_idle_txd"}, 32'(fifo_txd), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by randomized packets
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int len;
    int md;
    int ea;
    int nsave;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_outputs", {29'd0, fifo_txen, fd, abort}, 32'd0);
    check("rst_txd", 32'(fifo_txd), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt_o), 32'd0);

    run_pkt("basic",       6, 0, 8'h00, 0,  -1);
    run_pkt("backpress",   6, 0, 8'h00, 50, -1);
    run_pkt("lfsr_s01",    7, 3, 8'h01, 0,  -1);
    run_pkt("lfsr_s00",    7, 3, 8'h00, 30, -1);
    run_pkt("abort",      10, 0, 8'h00, 0,   3);
    run_pkt("after_abort", 6, 1, 8'h3C, 20, -1);
    run_pkt("len0",        0, 0, 8'h00, 0,  -1);
    run_pkt("len1",        1, 2, 8'h10, 40, -1);
    run_pkt("mode2_f0",    4, 2, 8'hF0, 0,  -1);

    for (int p = 0; p < 16; p++) begin
      len = $urandom_range(0, 24);
      md  = $urandom_range(0, 3);
      ea  = -1;
      if (len >= 8 && $urandom_range(0, 3) == 0) ea = $urandom_range(2, len - 3);
      run_pkt($sformatf("rnd%0d", p), len, md, int'($urandom_range(0, 255)),
              $urandom_range(0, 60), ea);
    end

    // Reset in the middle of a packet
    got_q.delete();
    @(posedge clk); #1;
    fs = 1'b1; data_len = 12'd20; mode = 2'd0; seed = 8'h00;
    k = 0;
    while (got_q.size() < 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("midrst_reached_work", 32'(k < 200), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; fs = 1'b0;
    @(negedge clk);
    exp_pkt = '0;
    check("midrst_txen", 32'(fifo_txen), 32'd0);
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("midrst_byte_cnt", 32'(byte_cnt_o), 32'd0);
    nsave = got_q.size();
    repeat (5) @(negedge clk);
    check("midrst_no_writes", 32'(got_q.size()), 32'(nsave));

    run_pkt("post_rst", 5, 0, 8'h00, 10, -1);
    check("no_write_when_full", 32'(bad_wr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_gen.md
Name: fifo_pkt_gen

Overview:
- Parametrised test-packet source that writes a framed byte stream into a downstream FIFO write port under an fs/fd start/done handshake.
- Successor of the fixed 128-entry, 8-bit, incrementing-table writer.
- Adds:
  - width and length parameters
  - selectable payload patterns
  - FIFO-full backpressure
  - error abort
  - a packet counter
- Sits between the test controller, which drives fs, data_len and mode, and the FIFO under test.

Parameters:
DATA_W, 8, width of fifo_txd and pattern datapath (>=8)
LEN_W, 12, width of data_len and byte counter
HEAD0, 8'h55, first header word (zero-extended to DATA_W)
HEAD1, 8'hAA, second header word (zero-extended to DATA_W)
LFSR_TAPS, 8'hB8, feedback tap mask for mode 3 (zero-extended to DATA_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
fs  in  1  start request, level; must drop after fd before next packet
data_len  in  LEN_W  total words per packet including the two header words
mode  in  2  payload pattern select
seed  in  DATA_W  pattern seed
err  in  1  abort request
fifo_full  in  1  downstream FIFO full
fifo_txd  out  DATA_W  write data
fifo_txen  out  1  write enable
fd  out  1  packet done
abort  out  1  packet aborted
pkt_cnt  out  16  completed packets, wraps FFFF->0000
state_o  out  3  current state (debug)
byte_cnt_o  out  LEN_W  words written in current packet (debug)

Behaviour:
- **Reset:** all state is synchronous to clk. rst high at an edge forces, from the next cycle:
  - state=IDLE
  - idx=0, pkt_cnt=0
  - fd=0, abort=0, fifo_txen=0, fifo_txd=0
- **Mid-packet reset:** rst during a packet discards it. No further writes occur.
- **States:** IDLE=0, HEAD=1, WORK=2, LAST=3, ABORT=4. Undefined encodings go to IDLE.
- **IDLE -> HEAD:** when fs=1. In that cycle, latch len=data_len, pmode=mode, and the pattern register (seed; in mode 3 a seed of 0 is replaced by 1).
- **HEAD:** one cycle, no write, idx<=0.
  - -> LAST if len==0.
  - else -> WORK.
- **WORK:**
  - fifo_txen = !fifo_full (combinational).
  - idx increments only on a cycle with fifo_txen=1.
  - When fifo_txen=1 and idx==len-1 -> LAST.
  - fifo_full held indefinitely stalls in WORK with no data loss.
- **Word at index i:**
  - i=0: HEAD0.
  - i=1: HEAD1.
  - i>=2, by latched mode:
    - 0: i[DATA_W-1:0]
    - 1: seed constant
    - 2: seed+i, modulo 2^DATA_W
    - 3: LFSR register; after each payload write it shifts: reg <= {reg[DATA_W-2:0], ^(reg & LFSR_TAPS)}
- **fifo_txd:** equals the current-index word while in WORK, else 0.
- **len==1:** only HEAD0 is written.
- **LAST:**
  - fd=1.
  - pkt_cnt increments once on entry.
  - -> IDLE when fs=0. fs held high keeps LAST; there is no auto-restart.
- **err:** err=1 in HEAD or WORK -> ABORT on the next edge.
  - The write in that cycle still occurs if fifo_txen=1.
  - ABORT: abort=1, fd=0, no writes, pkt_cnt unchanged.
  - ABORT -> IDLE when fs=0.
  - err is ignored in IDLE and LAST.
- **byte_cnt_o:** equals idx and returns to 0 in IDLE.
- **Data_len changes:** changes after the IDLE->HEAD transition have no effect.

Optional Feature:
- Macro: FIFO_PKT_GEN_CHECKSUM_EN.
- **Defined:** after word len-1 is written, WORK stays for one extra write of a trailer word.
  - Trailer = XOR of all len words written (header included).
  - The trailer obeys fifo_full and is not counted in len.
  - LAST is entered after the trailer is written.
  - len==0 writes the trailer 0 only.
  - err during a pending trailer aborts it.
- **Undefined:** no trailer, no checksum logic.

Test Plan:
- **Basic packet:** mode=0, data_len=6, fs held, fifo_full=0.
  - Expected: 6 consecutive fifo_txen pulses carrying 55 AA 02 03 04 05, then fd=1, pkt_cnt=1.
  - fs low -> IDLE.
  - With checksum: trailer FF follows, 7 writes total.
- **Backpressure:** same as basic packet, with fifo_full high for 3 cycles after the 3rd write.
  - Expected: identical 6-word sequence, fifo_txen=0 during the stall, fd delayed 3 cycles.
- **LFSR pattern:** mode=3, seed=01, data_len=7.
  - Expected: 55 AA 01 02 04 08 11.
  - Repeat with seed=00: payload starts at 01.
- **Abort:** err pulsed one cycle after the 3rd write, data_len=10.
  - Expected: abort=1, no further writes, fd never 1, pkt_cnt unchanged.
  - fs low -> IDLE; next packet completes normally.
- **Edge lengths:** data_len=0 gives zero writes, then fd=1. data_len=1 gives single write 55. mode=2, seed=F0, data_len=4 gives 55 AA F2 F3.
- **Reset mid-packet and counter wrap:**
  - rst during WORK: fifo_txen=0 and state=IDLE next cycle, pkt_cnt=0.
  - 65536 completed packets: pkt_cnt wraps to 0000.
